// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key input plus debounced strobes/level of one key_debounce
// Ports: key_in raw active-low key; key_pulse press strobe; rel_pulse release strobe;
//        key_state debounced level (1 = held). slave = debouncer side, master = key/consumer side.
interface key_debounce_if;
  logic key_in;
  logic key_pulse;
  logic rel_pulse;
  logic key_state;
  modport master (output key_in, input key_pulse, rel_pulse, key_state);
  modport slave (input key_in, output key_pulse, rel_pulse, key_state);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a bouncing active-low key and qualifies each level change for CNT_MAX cycles
// Ports: sys_clk clock; sys_rst synchronous active-high reset;
//        kb.key_in raw key (0 = pressed); kb.key_pulse one-cycle press strobe;
//        kb.rel_pulse one-cycle release strobe; kb.key_state debounced level (1 = held)
module key_debounce #(
  parameter int unsigned CNT_MAX = 1_000_000
) (
  input logic sys_clk,
  input logic sys_rst,
  key_debounce_if.slave kb
);
  localparam int W = $clog2(CNT_MAX);
  localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);
  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;
  state_t state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic sync1, key_sync;
  logic key_pulse_nxt, rel_pulse_nxt, key_state_nxt;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 1'b1;
      key_sync <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      kb.key_pulse <= 1'b0;
      kb.rel_pulse <= 1'b0;
      kb.key_state <= 1'b0;
    end else begin
      sync1 <= kb.key_in;
      key_sync <= sync1;
      state <= state_nxt;
      cnt <= cnt_nxt;
      kb.key_pulse <= key_pulse_nxt;
      kb.rel_pulse <= rel_pulse_nxt;
      kb.key_state <= key_state_nxt;
    end
  end
  // Filter states count consecutive cycles at the new level; any return to the old level restarts from the stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    key_pulse_nxt = 1'b0;
    rel_pulse_nxt = 1'b0;
    key_state_nxt = kb.key_state;
    case (state)
      IDLE: begin
        if (!key_sync) begin
          state_nxt = PRESS_FILT;
          cnt_nxt = '0;
        end
      end
      PRESS_FILT: begin
        if (key_sync) begin
          state_nxt = IDLE;
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = DOWN;
          cnt_nxt = '0;
          key_pulse_nxt = 1'b1;
          key_state_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + W'(1);
        end
      end
      DOWN: begin
        if (key_sync) begin
          state_nxt = REL_FILT;
          cnt_nxt = '0;
        end
      end
      REL_FILT: begin
        if (!key_sync) begin
          state_nxt = DOWN;
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt = '0;
          rel_pulse_nxt = 1'b1;
          key_state_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + W'(1);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized and directed checks of key_debounce against a run-length reference model
module tb_key_debounce;
  localparam int CNT_MAX = 8;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int total = 0;
  int bad = 0;
  key_debounce_if kif();
  key_debounce #(.CNT_MAX(CNT_MAX)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .kb(kif));
  always #5 sys_clk = ~sys_clk;
  // Reference model: the FSM sees the raw key two edges late; the debounced level flips once the
  // delayed key has disagreed with it for CNT_MAX+1 consecutive edges, emitting one strobe.
  bit hist[$];
  bit m_down, ks_seen, exp_kp, exp_rp, exp_ks;
  int run;
  initial begin
    hist.push_back(1'b1);
    hist.push_back(1'b1);
    forever begin
      @(posedge sys_clk);
      exp_kp = 1'b0;
      exp_rp = 1'b0;
      if (sys_rst) begin
        hist.delete();
        hist.push_back(1'b1);
        hist.push_back(1'b1);
        m_down = 1'b0;
        run = 0;
      end else begin
        ks_seen = hist.pop_front();
        hist.push_back(kif.key_in);
        run = (ks_seen == m_down) ? run + 1 : 0;
        if (run == CNT_MAX + 1) begin
          m_down = !m_down;
          run = 0;
          exp_kp = m_down;
          exp_rp = !m_down;
        end
      end
      exp_ks = m_down;
    end
  end
  task automatic test_reset();
    kif.key_in = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== 3'b000) begin
        bad++;
        $display("FAIL reset cyc %0d: got %b want 000", i, {kif.key_pulse, kif.rel_pulse, kif.key_state});
      end
      kif.key_in = 1'($urandom);
    end
    sys_rst = 1'b0;
    kif.key_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== 3'b000) begin
        bad++;
        $display("FAIL reset_idle cyc %0d: got %b want 000", i, {kif.key_pulse, kif.rel_pulse, kif.key_state});
      end
    end
  endtask
  task automatic test_clean_press();
    logic [2:0] want;
    kif.key_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      want = {k == 11, 1'b0, k >= 11};
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== want) begin
        bad++;
        $display("FAIL clean_press edge %0d: got %b want %b", k, {kif.key_pulse, kif.rel_pulse, kif.key_state}, want);
      end
    end
    kif.key_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      want = {1'b0, k == 11, k < 11};
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== want) begin
        bad++;
        $display("FAIL clean_release edge %0d: got %b want %b", k, {kif.key_pulse, kif.rel_pulse, kif.key_state}, want);
      end
    end
  endtask
  task automatic test_bounce_reject();
    int len[4] = '{5, 3, 4, 20};
    for (int s = 0; s < 4; s++) begin
      kif.key_in = s[0];
      for (int i = 0; i < len[s]; i++) begin
        @(negedge sys_clk);
        total++;
        if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== 3'b000) begin
          bad++;
          $display("FAIL bounce_reject seg %0d cyc %0d: got %b want 000", s, i, {kif.key_pulse, kif.rel_pulse, kif.key_state});
        end
      end
    end
  endtask
  task automatic test_bouncy_hold();
    int len[6] = '{2, 1, 3, 2, 100, 20};
    int kp_n = 0;
    for (int s = 0; s < 6; s++) begin
      kif.key_in = s[0];
      for (int i = 0; i < len[s]; i++) begin
        @(negedge sys_clk);
        kp_n += int'(kif.key_pulse);
        total++;
        if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== {exp_kp, exp_rp, exp_ks}) begin
          bad++;
          $display("FAIL bouncy_hold seg %0d cyc %0d: got %b want %b", s, i, {kif.key_pulse, kif.rel_pulse, kif.key_state}, {exp_kp, exp_rp, exp_ks});
        end
      end
    end
    total++;
    if (kp_n !== 1) begin
      bad++;
      $display("FAIL bouncy_hold_count: got %0d key_pulse want 1", kp_n);
    end
  endtask
  task automatic test_release_bounce();
    int len[3] = '{15, 3, 2};
    logic [2:0] want;
    for (int s = 0; s < 3; s++) begin
      kif.key_in = s[0];
      for (int i = 0; i < len[s]; i++) begin
        @(negedge sys_clk);
        want = (s == 0) ? {i == 10, 1'b0, i >= 10} : 3'b001;
        total++;
        if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== want) begin
          bad++;
          $display("FAIL release_bounce seg %0d cyc %0d: got %b want %b", s, i, {kif.key_pulse, kif.rel_pulse, kif.key_state}, want);
        end
      end
    end
    kif.key_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      want = {1'b0, k == 11, k < 11};
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== want) begin
        bad++;
        $display("FAIL release_final edge %0d: got %b want %b", k, {kif.key_pulse, kif.rel_pulse, kif.key_state}, want);
      end
    end
  endtask
  task automatic test_reset_mid();
    int pre[2] = '{5, 0};
    logic [2:0] want;
    kif.key_in = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat (pre[r]) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== 3'b000) begin
        bad++;
        $display("FAIL reset_mid %0d: got %b want 000", r, {kif.key_pulse, kif.rel_pulse, kif.key_state});
      end
      for (int k = 1; k <= 14; k++) begin
        @(negedge sys_clk);
        want = {k == 11, 1'b0, k >= 11};
        total++;
        if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== want) begin
          bad++;
          $display("FAIL reset_mid_repress %0d edge %0d: got %b want %b", r, k, {kif.key_pulse, kif.rel_pulse, kif.key_state}, want);
        end
      end
    end
    kif.key_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== {exp_kp, exp_rp, exp_ks}) begin
        bad++;
        $display("FAIL reset_mid_release cyc %0d: got %b want %b", i, {kif.key_pulse, kif.rel_pulse, kif.key_state}, {exp_kp, exp_rp, exp_ks});
      end
    end
  endtask
  task automatic test_back_to_back();
    int kp_n = 0;
    int rp_n = 0;
    int last = 2;
    for (int s = 0; s < 8; s++) begin
      kif.key_in = s[0];
      for (int i = 0; i < 12; i++) begin
        @(negedge sys_clk);
        total++;
        if ((kif.key_pulse && (kif.rel_pulse || last == 1)) || (kif.rel_pulse && last == 2)) begin
          bad++;
          $display("FAIL back_to_back_order seg %0d cyc %0d: got kp=%b rp=%b after %0d", s, i, kif.key_pulse, kif.rel_pulse, last);
        end
        if (kif.key_pulse) begin
          kp_n++;
          last = 1;
        end
        if (kif.rel_pulse) begin
          rp_n++;
          last = 2;
        end
      end
    end
    total++;
    if (kp_n !== 4 || rp_n !== 4) begin
      bad++;
      $display("FAIL back_to_back_count: got %0d/%0d want 4/4", kp_n, rp_n);
    end
  endtask
  task automatic test_random();
    int len;
    for (int s = 0; s < 200; s++) begin
      kif.key_in = ~kif.key_in;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 14) : $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        sys_rst = ($urandom_range(0, 199) == 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        total++;
        if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== {exp_kp, exp_rp, exp_ks}) begin
          bad++;
          $display("FAIL random seg %0d cyc %0d: got %b want %b", s, i, {kif.key_pulse, kif.rel_pulse, kif.key_state}, {exp_kp, exp_rp, exp_ks});
        end
      end
    end
    kif.key_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk);
      total++;
      if ({kif.key_pulse, kif.rel_pulse, kif.key_state} !== {exp_kp, exp_rp, exp_ks}) begin
        bad++;
        $display("FAIL random_tail cyc %0d: got %b want %b", i, {kif.key_pulse, kif.rel_pulse, kif.key_state}, {exp_kp, exp_rp, exp_ks});
      end
    end
  endtask
  initial begin
    kif.key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bouncy_hold();
    test_release_bounce();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter: CNT_MAX, default 1_000_000, qualification time in sys_clk cycles (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 Port: sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: sys_rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_in  input  1  raw mechanical key, asynchronous to sys_clk, active-low (0 = pressed), bouncing.
REQ-005 Port: key_pulse  output  1  one-cycle strobe per qualified press; drives a downstream press counter's key_pulse input directly.
REQ-006 Port: rel_pulse  output  1  one-cycle strobe per qualified release.
REQ-007 Port: key_state  output  1  debounced level, 1 = key held down.

Function
REQ-008 key_in SHALL pass through a two-flop synchronizer; the second stage (key_sync) is the only FSM input derived from key_in.
REQ-009 Qualification counter width SHALL be clog2(CNT_MAX); the counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-010 The FSM SHALL have four states: IDLE (released, stable), PRESS_FILT, DOWN (pressed, stable), and REL_FILT.
REQ-011 IDLE: key_sync=0 -> PRESS_FILT, counter cleared; otherwise remain.
REQ-012 PRESS_FILT: key_sync=1 -> IDLE, counter cleared (bounce rejected, no pulse).
REQ-013 PRESS_FILT: key_sync=0 with counter<CNT_MAX-1 -> counter+1; key_sync=0 with counter=CNT_MAX-1 -> DOWN.
REQ-014 DOWN: key_sync=1 -> REL_FILT, counter cleared; otherwise remain, with no further pulses however long the key is held.
REQ-015 REL_FILT: key_sync=0 -> DOWN, counter cleared (release bounce rejected, no pulse, key_state stays 1).
REQ-016 REL_FILT: key_sync=1 with counter<CNT_MAX-1 -> counter+1; key_sync=1 with counter=CNT_MAX-1 -> IDLE.
REQ-017 key_pulse SHALL be a registered output, high for exactly the one cycle after the PRESS_FILT->DOWN transition edge, and low at all other times.
REQ-018 rel_pulse SHALL be a registered output, high for exactly the one cycle after the REL_FILT->IDLE transition edge, and low at all other times.
REQ-019 key_state SHALL be registered: it rises in the same cycle key_pulse rises and falls in the same cycle rel_pulse rises.
REQ-020 key_pulse and rel_pulse SHALL never be high in the same cycle.
REQ-021 Press latency: if edge 1 is the first edge sampling key_in=0 and key_in stays low, key_pulse SHALL be high in the cycle following edge CNT_MAX+3.
REQ-022 Release latency SHALL be symmetric: rel_pulse is high in the cycle following edge CNT_MAX+3, counted from the first edge sampling key_in=1.
REQ-023 Each full press/release cycle SHALL produce at most one key_pulse and at most one rel_pulse.
REQ-024 A low phase shorter than CNT_MAX consecutive synchronized cycles SHALL produce no output change.

Reset
REQ-025 While sys_rst=1 at a rising edge, both synchronizer flops SHALL load 1, the FSM SHALL go to IDLE, the counter SHALL load 0, and key_pulse, rel_pulse and key_state SHALL load 0.
REQ-026 sys_rst SHALL override all other inputs in every state, including a reset asserted during PRESS_FILT, DOWN or REL_FILT.
REQ-027 If the key is held low through reset deassertion, the block SHALL treat it as a new press: full CNT_MAX qualification, then one key_pulse.

Verification (CNT_MAX=8)
REQ-028 Clean press: key_in 1->0, held 20 cycles -> key_pulse high only in the cycle after edge 11; key_state=1 from that cycle.
REQ-029 Bounce reject: key_in low 5 cycles, high 3, low 4, high -> key_pulse, rel_pulse and key_state remain 0 throughout.
REQ-030 Bouncy press then hold 100 cycles -> exactly one key_pulse; no repeat while held.
REQ-031 Release with bounce: from DOWN, key_in high 3 cycles, low 2, then high steadily -> key_state stays 1 through the bounce; one rel_pulse 11 cycles after the final rising edge is first sampled.
REQ-032 Reset mid-operation: sys_rst pulsed for 1 cycle in PRESS_FILT and again in DOWN -> all outputs 0 the next cycle; key still held -> new key_pulse 11 edges after reset release.
REQ-033 Four qualified press/release cycles -> exactly four key_pulse and four rel_pulse strobes, alternating, never coincident.
